// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART polling engine.
package uart_pkg;

   // Status register bit positions as returned by the UART on a status read
   localparam int STAT_TX_BUSY = 15;
   localparam int STAT_RX_FULL = 14;

   // Register select values on ua_a0
   localparam logic A0_STATUS = 1'b0;
   localparam logic A0_DATA   = 1'b1;

   // Polling engine states; the encoding is also visible on the fsm_state debug port
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_POLL = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Pointers carry one extra wrap bit, so level is simply wr_ptr - rd_ptr.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_b,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign level   = wr_ptr - rd_ptr;
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Head reads as zero while empty so the client never sees stale data
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Storage array: written on accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Read and write pointers advance on accepted pop and push
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_poller.sv
// Bus initiator that turns the UART register port into two byte streams.
// The engine polls the status register; a POLL that finds rx_full (and RX
// FIFO space) is followed by a data read, otherwise a POLL that finds the
// transmitter idle (and TX data queued) is followed by a data write.
// Every access is one cycle with cs_b low. Bus outputs are registered from
// the next-state value, so ua_din never reaches ua_* combinationally.
// Client handshakes: a transfer happens on a rising edge where valid and
// ready are both high; valid may not depend on ready.
module uart_poller
   import uart_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int POLL_GAP = 0
) (
   input  logic                     clk,
   input  logic                     reset_b,
   input  logic                     enable,
   output logic                     ua_cs_b,
   output logic                     ua_rnw,
   output logic                     ua_a0,
   output logic [15:0]              ua_dout,
   input  logic [15:0]              ua_din,
   input  logic [7:0]               tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic [7:0]               rx_data,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [$clog2(DEPTH):0]   tx_level,
   output logic [$clog2(DEPTH):0]   rx_level,
   output logic [2:0]               fsm_state
);

   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

   state_t        state;
   state_t        nxt;
   logic [GW-1:0] gap_cnt;

   logic [7:0] tx_head;
   logic       tx_full;
   logic       tx_empty;
   logic       rx_full;
   logic       rx_empty;
   logic       unused_din;

   // Status bits other than tx_busy/rx_full are don't-care
   assign unused_din = ^ua_din[13:8];

   assign tx_ready  = ~tx_full;
   assign rx_valid  = ~rx_empty;
   assign fsm_state = state;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset_b   (reset_b),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (state == ST_WR),
      .head      (tx_head),
      .level     (tx_level),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clk),
      .reset_b   (reset_b),
      .push      (state == ST_RD),
      .push_data (ua_din[7:0]),
      .pop       (rx_ready),
      .head      (rx_data),
      .level     (rx_level),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // Next-state decision; POLL uses the status word present at the end of the cycle
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: if (enable) nxt = ST_POLL;
         ST_POLL: begin
            if (!enable)
               nxt = ST_IDLE;
            else if (ua_din[STAT_RX_FULL] && !rx_full)
               nxt = ST_RD;
            else if (!ua_din[STAT_TX_BUSY] && !tx_empty)
               nxt = ST_WR;
            else if (POLL_GAP > 0)
               nxt = ST_GAP;
            else
               nxt = ST_POLL;
         end
         ST_RD, ST_WR: nxt = enable ? ST_POLL : ST_IDLE;
         ST_GAP: begin
            if (!enable)
               nxt = ST_IDLE;
            else if (gap_cnt == '0)
               nxt = ST_POLL;
            else
               nxt = ST_GAP;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // State register, gap down-counter and registered bus outputs for the upcoming cycle
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state   <= ST_IDLE;
         gap_cnt <= '0;
         ua_cs_b <= 1'b1;
         ua_rnw  <= 1'b1;
         ua_a0   <= A0_STATUS;
         ua_dout <= 16'h0000;
      end else begin
         state <= nxt;
         if (state == ST_POLL && nxt == ST_GAP)
            gap_cnt <= GAP_LOAD;
         else if (state == ST_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
         ua_cs_b <= !(nxt == ST_POLL || nxt == ST_RD || nxt == ST_WR);
         ua_rnw  <= (nxt != ST_WR);
         ua_a0   <= (nxt == ST_RD || nxt == ST_WR) ? A0_DATA : A0_STATUS;
         // TX head cannot change between the authorising POLL and the WR
         ua_dout <= (nxt == ST_WR) ? {8'h00, tx_head} : 16'h0000;
      end
   end

endmodule
